// File: rtl/recv_img_if.sv
// Pixel write bus and status strobes from the UART image loader.
interface recv_img_if #(
    parameter int ADDR_WIDTH = 14
);
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [7:0]            write_data;
    logic                  write_enable;
    logic                  full_image_received;
    logic                  receiving;
    logic                  framing_error;

    modport master (
        output write_addr,
        output write_data,
        output write_enable,
        output full_image_received,
        output receiving,
        output framing_error
    );

    modport slave (
        input write_addr,
        input write_data,
        input write_enable,
        input full_image_received,
        input receiving,
        input framing_error
    );
endinterface

// File: rtl/recv_img.sv
// UART 8N1 to BRAM image loader; one byte per pixel in raster order.
// Optional SYNC_BYTE_EN: hunt for SYNC_BYTE before each frame.
module recv_img #(
    parameter int         CLOCKS_PER_BAUD = 50,
    parameter int         BRAM_LENGTH     = 4096,
    parameter int         ADDR_WIDTH      = 14,
    parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
    input  logic      clk,
    input  logic      rst_in,
    input  logic      rx,
    recv_img_if.master bus
);
    localparam int BW = $clog2(CLOCKS_PER_BAUD) + 1;
    localparam logic [BW-1:0] HALF_M1 =
        BW'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [BW-1:0] FULL_M1 =
        BW'(CLOCKS_PER_BAUD - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(BRAM_LENGTH - 1);
`ifdef SYNC_BYTE_EN
    localparam logic HUNT_ON = 1'b1;
`else
    localparam logic HUNT_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_m, rx_s;
    logic [BW-1:0]         baud_q, baud_d;
    logic [3:0]            bit_q, bit_d;
    logic [7:0]            sh_q, sh_d;
    logic                  byte_ok, stop_err, accept;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            data_q;
    logic                  we_q, full_q, recv_q, ferr_q;
    logic                  hunt_q;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        byte_ok  = 1'b0;
        stop_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (baud_q == HALF_M1) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == FULL_M1) begin
                    baud_d = '0;
                    sh_d   = {rx_s, sh_q[7:1]};
                    bit_d  = bit_q + 4'd1;
                    if (bit_q == 4'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == FULL_M1) begin
                    baud_d = '0;
                    if (rx_s) begin
                        byte_ok = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_err = 1'b1;
                        state_d  = WAIT_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = byte_ok && !hunt_q;

    // Write path: strobe the cycle after the stop sample, step address after.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            full_q <= 1'b0;
            recv_q <= 1'b0;
            ferr_q <= 1'b0;
            hunt_q <= HUNT_ON;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            we_q   <= accept;
            ferr_q <= stop_err;
            full_q <= we_q && (addr_q == LAST_ADDR);
            if (accept) begin
                data_q <= sh_q;
                if (addr_q == '0) recv_q <= 1'b1;
            end
            if (byte_ok && hunt_q && sh_q == SYNC_BYTE) begin
                hunt_q <= 1'b0;
            end
            if (we_q) begin
                if (addr_q == LAST_ADDR) begin
                    addr_q <= '0;
                    recv_q <= 1'b0;
                    hunt_q <= HUNT_ON;
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
            end
        end
    end

    assign bus.write_addr          = addr_q;
    assign bus.write_data          = data_q;
    assign bus.write_enable        = we_q;
    assign bus.full_image_received = full_q;
    assign bus.receiving           = recv_q;
    assign bus.framing_error       = ferr_q;
endmodule
